// File: rtl/dualrail_rx.sv
// dualrail_rx: dual-rail bit-serial link receiver; four-phase per-bit ack, word assembly, consumer handoff
module dualrail_rx #(
    parameter int NBITS       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Dt,
    input  logic             bit0,
    input  logic             bit1,
    output logic             ack,
    output logic             senack,
    output logic [NBITS-1:0] data,
    output logic             valid,
    input  logic             rd_ack,
    output logic             err
);
    localparam int CW = $clog2(NBITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WAIT_BIT, ACK_HI, DONE, SEN, ERR} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync0, sync1, synct;
    logic                   s0, s1, sdt, timeout;
    logic [CW-1:0]          count, count_n;
    logic [TW-1:0]          timer, timer_n;
    logic [NBITS-1:0]       data_n;
    logic                   ack_n, senack_n, valid_n, err_n;

    assign s0      = sync0[SYNC_STAGES-1];
    assign s1      = sync1[SYNC_STAGES-1];
    assign sdt     = synct[SYNC_STAGES-1];
    assign timeout = timer == TW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0  <= '0;
            sync1  <= '0;
            synct  <= '0;
            state  <= IDLE;
            count  <= '0;
            timer  <= '0;
            data   <= '0;
            ack    <= 1'b0;
            senack <= 1'b0;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else begin
            sync0  <= {sync0[SYNC_STAGES-2:0], bit0};
            sync1  <= {sync1[SYNC_STAGES-2:0], bit1};
            synct  <= {synct[SYNC_STAGES-2:0], Dt};
            state  <= state_n;
            count  <= count_n;
            timer  <= timer_n;
            data   <= data_n;
            ack    <= ack_n;
            senack <= senack_n;
            valid  <= valid_n;
            err    <= err_n;
        end
    end

    // Abort on Dt loss outranks every rail event; timeout is the lowest priority.
    always_comb begin
        state_n  = state;
        count_n  = count;
        data_n   = data;
        ack_n    = ack;
        senack_n = senack;
        valid_n  = valid;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (sdt) begin
                    state_n = WAIT_BIT;
                    count_n = '0;
                end
            end
            WAIT_BIT: begin
                if (!sdt) begin
                    err_n   = 1'b1;
                    count_n = '0;
                    state_n = IDLE;
                end else if (s0 && s1) begin
                    err_n   = 1'b1;
                    state_n = ERR;
                end else if (s0 ^ s1) begin
                    data_n  = (data & ~(NBITS'(1) << count)) | (NBITS'(s1) << count);
                    ack_n   = 1'b1;
                    state_n = ACK_HI;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = ERR;
                end
            end
            ACK_HI: begin
                if (!sdt) begin
                    err_n   = 1'b1;
                    ack_n   = 1'b0;
                    count_n = '0;
                    state_n = IDLE;
                end else if (!s0 && !s1) begin
                    ack_n   = 1'b0;
                    count_n = count + 1'b1;
                    valid_n = count_n == CW'(NBITS);
                    state_n = valid_n ? DONE : WAIT_BIT;
                end else if (timeout) begin
                    err_n   = 1'b1;
                    ack_n   = 1'b0;
                    state_n = ERR;
                end
            end
            DONE: begin
                if (rd_ack) begin
                    valid_n  = 1'b0;
                    senack_n = 1'b1;
                    state_n  = SEN;
                end
            end
            SEN: begin
                if (!sdt) begin
                    senack_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            ERR: begin
                ack_n    = 1'b0;
                senack_n = 1'b0;
                state_n  = (!s0 && !s1 && !sdt) ? IDLE : ERR;
            end
            default: state_n = IDLE;
        endcase
        timer_n = (state_n == state && (state == WAIT_BIT || state == ACK_HI)) ? timer + 1'b1 : '0;
    end
endmodule

// File: tb/tb_dualrail_rx.sv
// tb_dualrail_rx: directed sender model with a scoreboard monitor for words and error pulses
module tb_dualrail_rx;
    localparam int N = 4;
    localparam logic [N:0] EV_ERR = {1'b1, {N{1'b0}}};

    logic         clk = 0, reset = 0, Dt = 0, bit0 = 0, bit1 = 0, rd_ack = 0;
    logic         ack, senack, valid, err;
    logic [N-1:0] data;
    int           vectors = 0, miscompares = 0, err_cnt = 0, ack_cnt = 0;
    logic [N:0]   exp_q[$];
    logic         valid_q = 0, ack_q = 0;

    dualrail_rx #(.NBITS(N), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .Dt(Dt), .bit0(bit0), .bit1(bit1), .ack(ack),
        .senack(senack), .data(data), .valid(valid), .rd_ack(rd_ack), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic score(input logic [N:0] got);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected event: got %0h expected none", got);
        end else check("scoreboard", {27'b0, got}, {27'b0, exp_q.pop_front()});
    endtask

    // Event 1 ns after each edge would collide with the driver; sample on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            valid_q = 0;
            ack_q   = 0;
        end else begin
            if (ack && !ack_q) ack_cnt++;
            if (valid && !valid_q) score({1'b0, data});
            if (err) begin
                err_cnt++;
                score(EV_ERR);
            end
            valid_q = valid;
            ack_q   = ack;
        end
    end

    function automatic logic sig(input int w);
        return w == 0 ? ack : w == 1 ? valid : senack;
    endfunction

    task automatic wait_until(input int which, input logic lvl, input string name);
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (sig(which) == lvl) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL timeout %s: signal never reached %0b", name, lvl);
    endtask

    task automatic send_bit(input logic b);
        bit0 = ~b;
        bit1 = b;
        wait_until(0, 1'b1, "ack high");
        bit0 = 0;
        bit1 = 0;
        wait_until(0, 1'b0, "ack low");
    endtask

    task automatic send_word(input logic [N-1:0] w, input int hold);
        int  a0;
        logic ok;
        exp_q.push_back({1'b0, w});
        a0 = ack_cnt;
        Dt = 1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) send_bit(w[i]);
        wait_until(1, 1'b1, "valid");
        check("ack pulses", ack_cnt - a0, N);
        ok = 1;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!(valid && data == w && !senack && !err)) ok = 0;
        end
        if (hold > 0) check("done stall stable", {31'b0, ok}, 1);
        rd_ack = 1;
        wait_until(2, 1'b1, "senack high");
        check("valid cleared", {31'b0, valid}, 0);
        rd_ack = 0;
        Dt     = 0;
        wait_until(2, 1'b0, "senack low");
        check("data held", {28'b0, data}, {28'b0, w});
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic ok;
        int   e0;
        repeat (3) @(posedge clk);
        #1;
        check("reset state", {27'b0, ack, senack, valid, err, data}, 0);
        reset = 1;
        repeat (2) @(posedge clk);
        #1;

        send_word(4'b1101, 0);

        exp_q.push_back(EV_ERR);
        Dt = 1;
        repeat (3) @(posedge clk);
        #1;
        bit0 = 1;
        bit1 = 1;
        ok   = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack) ok = 0;
        end
        check("no ack on both rails", {31'b0, ok}, 1);
        bit0 = 0;
        bit1 = 0;
        Dt   = 0;
        repeat (6) @(posedge clk);
        #1;
        check("both-rail err seen", exp_q.size(), 0);
        send_word(4'b0110, 0);

        exp_q.push_back(EV_ERR);
        Dt = 1;
        repeat (3) @(posedge clk);
        #1;
        send_bit(1);
        send_bit(1);
        Dt = 0;
        repeat (6) @(posedge clk);
        #1;
        check("abort err seen", exp_q.size(), 0);
        send_word(4'b0011, 0);

        exp_q.push_back(EV_ERR);
        e0 = err_cnt;
        Dt = 1;
        repeat (3) @(posedge clk);
        #1;
        bit1 = 1;
        wait_until(0, 1'b1, "ack timeout test");
        repeat (200) @(posedge clk);
        #1;
        check("no early timeout", err_cnt - e0, 0);
        repeat (100) @(posedge clk);
        #1;
        check("timeout err", err_cnt - e0, 1);
        check("ack after timeout", {31'b0, ack}, 0);
        bit1 = 0;
        repeat (10) @(posedge clk);
        bit1 = 1;
        repeat (10) @(posedge clk);
        #1;
        check("err state holds", {31'b0, ack}, 0);
        bit1 = 0;
        Dt   = 0;
        repeat (6) @(posedge clk);
        #1;

        send_word(4'b1010, 1000);

        Dt = 1;
        repeat (3) @(posedge clk);
        #1;
        send_bit(1);
        send_bit(0);
        bit1 = 1;
        wait_until(0, 1'b1, "ack reset test");
        #2 reset = 0;
        #1 check("reset mid-word", {27'b0, ack, senack, valid, err, data}, 0);
        bit1 = 0;
        Dt   = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #1;
        send_word(4'b1001, 0);

        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
